// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
//
// N-to-1 stream multiplexer with a one-entry registered output stage.
// Each input channel and the output use a valid/ready handshake. The channel
// is chosen either by the external select (fixed mode) or by a rotating
// round-robin pointer that starts its search just after the last winner.
//
// Parameters
//   WIDTH       data bits per channel (>= 1)
//   CHANNELS    number of input channels (>= 2)
//   SEL_WIDTH   select / pointer width, derived from CHANNELS
//   ROUND_ROBIN 0 = channel chosen by sel, 1 = round-robin (sel ignored)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        channel select used in fixed mode
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
// -----------------------------------------------------------------------------
module stream_mux #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SEL_WIDTH   = $clog2(CHANNELS),
    parameter int ROUND_ROBIN = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_WIDTH-1:0]      sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [SEL_WIDTH-1:0] r_rr_ptr;

    logic                 w_load_en;
    logic                 w_fx_valid;
    logic                 w_rr_valid;
    logic [SEL_WIDTH-1:0] w_rr_grant;
    logic                 w_grant_valid;
    logic [SEL_WIDTH-1:0] w_grant;
    logic [WIDTH-1:0]     w_grant_data;
    logic [CHANNELS-1:0]  w_in_ready;
    logic                 w_xfer;
    logic [SEL_WIDTH-1:0] w_ptr_next;

    // The stage can take a word when empty or when it is being drained now.
    assign w_load_en = !r_out_valid || out_ready;

    // Fixed-mode grant: sel must name an existing channel that is valid.
    // Comparing against each channel index keeps out-of-range selects from
    // ever indexing past in_valid.
    always_comb begin
        w_fx_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((int'(sel) == i) && in_valid[i]) begin
                w_fx_valid = 1'b1;
            end else begin
                w_fx_valid = w_fx_valid;
            end
        end
    end

    // Round-robin grant: first valid channel at or after the pointer,
    // wrapping. Scanning offsets from the far end down lets the nearest
    // valid channel be the last (winning) assignment.
    always_comb begin
        int idx;
        w_rr_valid = 1'b0;
        w_rr_grant = '0;
        idx        = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % CHANNELS;
            if (in_valid[idx]) begin
                w_rr_valid = 1'b1;
                w_rr_grant = idx[SEL_WIDTH-1:0];
            end else begin
                w_rr_valid = w_rr_valid;
            end
        end
    end

    // Pick the arbitration result for the configured mode.
    always_comb begin
        if (ROUND_ROBIN != 0) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = sel;
            w_grant_valid = w_fx_valid;
        end
    end

    // Route the granted channel's data and raise its ready bit only.
    always_comb begin
        w_grant_data = '0;
        w_in_ready   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(w_grant) == i) begin
                w_grant_data  = in_data[i*WIDTH +: WIDTH];
                w_in_ready[i] = w_load_en && w_grant_valid;
            end else begin
                w_in_ready[i] = 1'b0;
            end
        end
    end

    assign w_xfer = w_load_en && w_grant_valid;

    // Pointer successor of the winner, wrapping at CHANNELS (not 2**SEL_WIDTH).
    always_comb begin
        if (int'(w_grant) == (CHANNELS - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant + SEL_WIDTH'(1);
        end
    end

    // Output stage: load on transfer, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Round-robin pointer moves past the winner of each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= w_ptr_next;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_mux
//
// Three instances share one stimulus: a 4-channel fixed-select mux, a
// 3-channel fixed-select mux (so sel = 3 is out of range) and a 4-channel
// round-robin mux. A per-instance reference model built from the handshake
// rules predicts in_ready, out_valid and out_data every cycle.
// -----------------------------------------------------------------------------
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0] rdy_f4, rdy_rr;
    logic [2:0] rdy_f3;
    logic [7:0] dat_f4, dat_f3, dat_rr;
    logic       vld_f4, vld_f3, vld_rr;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: 0 = f4, 1 = f3, 2 = rr
    int       m_vld [3];
    int       m_dat [3];
    int       m_ptr [3];
    const int CH  [3] = '{4, 3, 4};
    const int RR  [3] = '{0, 0, 1};

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(0)) dut_f4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_f4), .sel(sel), .out_data(dat_f4), .out_valid(vld_f4),
        .out_ready(out_ready));

    stream_mux #(.WIDTH(8), .CHANNELS(3), .ROUND_ROBIN(0)) dut_f3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
        .in_ready(rdy_f3), .sel(sel), .out_data(dat_f3), .out_valid(vld_f3),
        .out_ready(out_ready));

    stream_mux #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_rr), .sel(sel), .out_data(dat_rr), .out_valid(vld_rr),
        .out_ready(out_ready));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // channel the rules grant to instance k this cycle, -1 for none
    function automatic int grant_of(int k);
        int c;
        if (RR[k] != 0) begin
            for (int o = 0; o < CH[k]; o++) begin
                c = (m_ptr[k] + o) % CH[k];
                if (in_valid[c]) return c;
            end
            return -1;
        end
        if ((int'(sel) < CH[k]) && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    function automatic int exp_ready(int k);
        int g;
        g = grant_of(k);
        if ((g >= 0) && ((m_vld[k] == 0) || out_ready)) return (1 << g);
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_vld[k] = 0;
            m_dat[k] = 0;
            m_ptr[k] = 0;
        end
    endtask

    task automatic check_dut(input int k, input string name, input logic [31:0] rdy,
                             input logic [31:0] vld, input logic [31:0] dat);
        check({name, " in_ready"},  rdy, exp_ready(k));
        check({name, " out_valid"}, vld, m_vld[k]);
        check({name, " out_data"},  dat, m_dat[k]);
    endtask

    // One clock: compare at the falling edge, advance the model across the
    // rising edge. Ends 1 time unit after the rising edge.
    task automatic tick();
        int nv [3];
        int nd [3];
        int np [3];
        int g;
        @(negedge clk);
        check_dut(0, "f4", {28'd0, rdy_f4}, {31'd0, vld_f4}, {24'd0, dat_f4});
        check_dut(1, "f3", {29'd0, rdy_f3}, {31'd0, vld_f3}, {24'd0, dat_f3});
        check_dut(2, "rr", {28'd0, rdy_rr}, {31'd0, vld_rr}, {24'd0, dat_rr});
        for (int k = 0; k < 3; k++) begin
            nv[k] = m_vld[k];
            nd[k] = m_dat[k];
            np[k] = m_ptr[k];
            g     = grant_of(k);
            if (!rst_n) begin
                nv[k] = 0;
                nd[k] = 0;
                np[k] = 0;
            end else if ((g >= 0) && ((m_vld[k] == 0) || out_ready)) begin
                nv[k] = 1;
                nd[k] = int'(in_data >> (8 * g)) & 255;
                np[k] = (g + 1) % CH[k];
            end else if ((m_vld[k] != 0) && out_ready) begin
                nv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_vld[k] = nv[k];
            m_dat[k] = nd[k];
            m_ptr[k] = np[k];
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 32'd0;
        in_valid  = 4'd0;
        sel       = 2'd0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check("reset f4 out_valid", {31'd0, vld_f4}, 32'd0);
        check("reset f4 out_data",  {24'd0, dat_f4}, 32'd0);
        check("reset rr out_valid", {31'd0, vld_rr}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fill then stall, then reset asynchronously mid-stream
        in_valid  = 4'hF;
        sel       = 2'd1;
        in_data   = 32'h44332211;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("stall f4 data", {24'd0, dat_f4}, 32'h22);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async f4 out_valid", {31'd0, vld_f4}, 32'd0);
        check("async f4 out_data",  {24'd0, dat_f4}, 32'd0);
        check("async f3 out_valid", {31'd0, vld_f3}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("first after release vld", {31'd0, vld_f4}, 32'd1);
        check("first after release dat", {24'd0, dat_f4}, 32'h22);

        // fixed mode, full rate
        sel     = 2'd2;
        in_data = 32'h00A50000;
        #1;
        check("fixed in_ready sel2", {28'd0, rdy_f4}, 32'b0100);
        tick();
        check("fixed A5 data", {24'd0, dat_f4}, 32'hA5);
        check("fixed A5 vld",  {31'd0, vld_f4}, 32'd1);
        for (int b = 1; b <= 3; b++) begin
            in_data = 32'(b) << 16;
            tick();
            check("fixed stream data", {24'd0, dat_f4}, 32'(b));
            check("fixed stream vld",  {31'd0, vld_f4}, 32'd1);
        end

        // back-pressure
        in_data = 32'h003C0000;
        tick();
        check("bp load 3C", {24'd0, dat_f4}, 32'h3C);
        out_ready = 1'b0;
        sel       = 2'd0;
        in_data   = 32'h11223344;
        #1;
        check("bp ready sel0", {28'd0, rdy_f4}, 32'd0);
        tick();
        check("bp hold sel0", {24'd0, dat_f4}, 32'h3C);
        sel     = 2'd3;
        in_data = 32'h5A6B7C8D;
        #1;
        check("bp ready sel3", {28'd0, rdy_f4}, 32'd0);
        tick();
        check("bp hold sel3", {24'd0, dat_f4}, 32'h3C);
        check("bp hold vld",  {31'd0, vld_f4}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp release ready", {28'd0, rdy_f4}, 32'b1000);
        tick();
        check("bp ch3 word", {24'd0, dat_f4}, 32'h5A);

        // invalid select on the 3-channel instance
        sel = 2'd0;
        tick();
        check("f3 loaded", {31'd0, vld_f3}, 32'd1);
        sel = 2'd3;
        #1;
        check("f3 sel3 ready", {29'd0, rdy_f3}, 32'd0);
        tick();
        check("f3 sel3 drained", {31'd0, vld_f3}, 32'd0);

        // round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_data  = 32'h13121110;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr fair", {24'd0, dat_rr}, 32'h10 + 32'(i % 4));
        end

        // round-robin skip: pointer is now 1
        in_valid = 4'b1001;
        tick();
        check("rr skip 1", {24'd0, dat_rr}, 32'h13);
        tick();
        check("rr skip 2", {24'd0, dat_rr}, 32'h10);
        tick();
        check("rr skip 3", {24'd0, dat_rr}, 32'h13);

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rand async vld", {31'd0, vld_rr}, 32'd0);
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
